// File: rtl/mcp4725_pkg.sv
// ---------------------------------------------------------------------------
// mcp4725_pkg
// Shared definitions for the MCP4725 DAC I2C write path:
//   - i2c_state_t : byte-level I2C write engine states
//   - MCP4725 7-bit address prefix
//   - command codes (fast write, write DAC, write DAC+EEPROM)
//   - power-down mode codes
// ---------------------------------------------------------------------------
package mcp4725_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    BIT_LO,
    BIT_HI,
    ACK_LO,
    ACK_HI,
    STOP_LO,
    STOP_HI,
    STOP_REL
  } i2c_state_t;

  // Upper four address bits of every MCP4725; A2..A0 follow, then R/W.
  localparam logic [3:0] MCP4725_ADDR_PREFIX = 4'b1100;

  localparam logic [1:0] CMD_FAST_WRITE       = 2'b00;
  localparam logic [2:0] CMD_WRITE_DAC        = 3'b010;
  localparam logic [2:0] CMD_WRITE_DAC_EEPROM = 3'b011;

  typedef enum logic [1:0] {
    PD_NORMAL = 2'b00,
    PD_1K     = 2'b01,
    PD_100K   = 2'b10,
    PD_500K   = 2'b11
  } pd_mode_t;

endpackage

// File: rtl/mcp4725_i2c_master_if.sv
// ---------------------------------------------------------------------------
// mcp4725_i2c_master_if
// Request/status bundle between the MCP4725 DAC front end and the I2C write
// engine.
//   start    : transaction request (sampled only while the engine is idle)
//   dev_addr : address byte incl. R/W bit (bit 0 = 0)
//   tx_data  : payload, byte 0 in the MSBs
//   tx_count : payload byte count, 0..TX_BYTES_MAX
//   busy     : transaction in progress
//   done     : one-cycle pulse at the end of a transaction
//   nack     : slave NACKed, held until the next accepted start
// modport master : requester side; modport slave : engine side.
// ---------------------------------------------------------------------------
interface mcp4725_i2c_master_if #(
  parameter int TX_BYTES_MAX = 3
);
  logic                      start;
  logic [7:0]                dev_addr;
  logic [8*TX_BYTES_MAX-1:0] tx_data;
  logic [1:0]                tx_count;
  logic                      busy;
  logic                      done;
  logic                      nack;

  modport master (
    output start, dev_addr, tx_data, tx_count,
    input  busy, done, nack
  );

  modport slave (
    input  start, dev_addr, tx_data, tx_count,
    output busy, done, nack
  );
endinterface

// File: rtl/i2c_byte_shifter.sv
// ---------------------------------------------------------------------------
// i2c_byte_shifter
// 8-bit load/shift register feeding the I2C data line MSB first.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_data and restart the bit counter
//   shift     : advance to the next bit (ignored while load is high)
//   bit_out   : bit currently presented to the bus
//   last_bit  : high while bit_out is the 8th bit of the byte
// ---------------------------------------------------------------------------
module i2c_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_data,
  output logic       bit_out,
  output logic       last_bit
);
  logic [7:0] sr;
  logic [2:0] bit_cnt;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= {sr[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign bit_out  = sr[7];
  assign last_bit = (bit_cnt == 3'd7);
endmodule

// File: rtl/mcp4725_i2c_master.sv
// ---------------------------------------------------------------------------
// mcp4725_i2c_master
// Byte-level I2C write engine for the MCP4725 DAC. Sends START, the address
// byte, 0..TX_BYTES_MAX payload bytes and STOP. Each state advances on one
// scl_tick (SCL half-period strobe); a frame takes 1 + 18*(n+1) + 3 ticks.
//   clk, rst  : clock, asynchronous active-low reset (releases the bus)
//   scl_tick  : one-cycle strobe per SCL half-period
//   bus       : request/status interface (slave modport)
//   SCL       : clock line, registered, high when released
//   SDA       : open-drain data line, only ever driven low
// Build option: define MCP4725_ACK_CHECK_EN to sample the slave ACK, flag
// nack and abort to STOP on a NACK. Without it ACKs are ignored and nack=0.
// ---------------------------------------------------------------------------
module mcp4725_i2c_master
  import mcp4725_pkg::*;
#(
  parameter int TX_BYTES_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_tick,
  mcp4725_i2c_master_if.slave  bus,
  output logic                 SCL,
  inout  wire                  SDA
);
  localparam int DW = 8 * TX_BYTES_MAX;

  i2c_state_t  state;
  logic [DW-1:0] payload;
  logic [1:0]  bytes_left;
  logic [1:0]  count_clamped;
  logic        sda_low;
  logic        busy_q;
  logic        done_q;
  logic        ack_fail;

  logic        sh_load;
  logic        sh_shift;
  logic [7:0]  sh_data;
  logic        sh_bit;
  logic        sh_last;

  assign count_clamped = (int'(bus.tx_count) > TX_BYTES_MAX) ? 2'(TX_BYTES_MAX)
                                                            : bus.tx_count;

  // Address byte is loaded on accept; each payload byte is loaded as the
  // previous ACK slot ends, so it is ready for the following BIT_LO.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = bus.dev_addr;
    if (state == IDLE && bus.start) begin
      sh_load = 1'b1;
    end else if (scl_tick && state == ACK_HI) begin
      sh_load = 1'b1;
      sh_data = payload[DW-1 -: 8];
    end
    if (scl_tick && state == BIT_HI) sh_shift = 1'b1;
  end

  i2c_byte_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_data),
    .bit_out   (sh_bit),
    .last_bit  (sh_last)
  );

`ifdef MCP4725_ACK_CHECK_EN
  logic nack_q;

  // Sampled just before SCL rises out of ACK_HI; the slave has been holding
  // its ACK since SCL fell in ACK_LO.
  assign ack_fail = (SDA == 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    nack_q <= 1'b0;
    else if (state == IDLE && bus.start)         nack_q <= 1'b0;
    else if (scl_tick && state == ACK_HI && ack_fail) nack_q <= 1'b1;
  end

  assign bus.nack = nack_q;
`else
  assign ack_fail = 1'b0;
  assign bus.nack = 1'b0;
`endif

  // Each tick applies the line levels of the state being left: SDA only
  // moves together with SCL falling, except START (tick in START) and STOP
  // (tick in STOP_REL), which move SDA while SCL is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      SCL        <= 1'b1;
      sda_low    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      payload    <= '0;
      bytes_left <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        // A tick in the accept cycle is dropped; START waits for the next one.
        if (bus.start) begin
          payload    <= bus.tx_data;
          bytes_left <= count_clamped;
          busy_q     <= 1'b1;
          state      <= START;
        end
      end else if (scl_tick) begin
        case (state)
          START: begin
            sda_low <= 1'b1;
            state   <= BIT_LO;
          end
          BIT_LO: begin
            SCL     <= 1'b0;
            sda_low <= ~sh_bit;
            state   <= BIT_HI;
          end
          BIT_HI: begin
            SCL   <= 1'b1;
            state <= sh_last ? ACK_LO : BIT_LO;
          end
          ACK_LO: begin
            SCL     <= 1'b0;
            sda_low <= 1'b0;
            state   <= ACK_HI;
          end
          ACK_HI: begin
            SCL <= 1'b1;
            if (bytes_left == 2'd0 || ack_fail) begin
              state <= STOP_LO;
            end else begin
              payload    <= payload << 8;
              bytes_left <= bytes_left - 2'd1;
              state      <= BIT_LO;
            end
          end
          STOP_LO: begin
            SCL     <= 1'b0;
            sda_low <= 1'b1;
            state   <= STOP_HI;
          end
          STOP_HI: begin
            SCL   <= 1'b1;
            state <= STOP_REL;
          end
          STOP_REL: begin
            sda_low <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign SDA      = sda_low ? 1'b0 : 1'bz;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mcp4725_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_mcp4725_i2c_master
// Self-checking bench for mcp4725_i2c_master: a table of frames with
// hand-computed tick counts and NACK results, a bus decoder / ACKing slave
// model, plus directed sequences for start-while-busy, coincident start and
// tick, and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_mcp4725_i2c_master;
  localparam int TXB  = 3;
  localparam int EV_S = -1;
  localparam int EV_P = -2;
  localparam int EV_A = 256;
  localparam int EV_N = 257;

  logic clk = 1'b0;
  logic rst;
  logic scl_tick;
  logic scl;
  logic slave_drive;
  wire  sda_bus;

  mcp4725_i2c_master_if #(.TX_BYTES_MAX(TXB)) bus ();

  mcp4725_i2c_master #(.TX_BYTES_MAX(TXB)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_tick (scl_tick),
    .bus      (bus),
    .SCL      (scl),
    .SDA      (sda_bus)
  );

  pullup (sda_bus);
  assign sda_bus = slave_drive ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] data;
    logic [1:0]  cnt;
    int          nack_byte;  // bus byte index the slave NACKs (0 = address), -1 none
    int          div;        // clk cycles per scl_tick
    int          exp_ticks;
    logic        exp_nack;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_div = 4;
  bit   tick_en  = 1'b0;
  int   tick_ph  = 0;
  int   tick_cnt = 0;
  int   done_cnt = 0;
  int   nack_byte = -1;
  int   ev[$];
  int   exp_ev[$];
  vec_t vecs[6];
  vec_t v0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // SCL half-period strobe, updated just after each rising edge.
  initial begin
    scl_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_ph >= tick_div - 1) tick_ph = 0;
      else                         tick_ph++;
      scl_tick = tick_en && (tick_ph == 0);
    end
  end

  // Bus decoder, tick/done counters and ACKing slave, all sampled on the
  // falling clk edge.
  initial begin
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       scl_now;
    logic       sda_now;
    logic [7:0] cur_byte = '0;
    int         bit_cnt  = 0;
    int         byte_idx = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (scl_tick && bus.busy) tick_cnt++;
        if (bus.done) done_cnt++;
      end
      scl_now = scl;
      sda_now = sda_bus;
      if (prev_scl && scl_now && prev_sda && !sda_now) begin
        ev.push_back(EV_S);
        bit_cnt  = 0;
        byte_idx = 0;
      end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
        ev.push_back(EV_P);
      end else if (!prev_scl && scl_now) begin
        if (bit_cnt < 8) begin
          cur_byte = {cur_byte[6:0], sda_now};
          bit_cnt++;
          if (bit_cnt == 8) ev.push_back(int'(cur_byte));
        end else begin
          ev.push_back(sda_now ? EV_N : EV_A);
          bit_cnt = 0;
          byte_idx++;
        end
      end else if (prev_scl && !scl_now) begin
        if (slave_drive)                                   slave_drive = 1'b0;
        else if (bit_cnt == 8 && byte_idx != nack_byte)    slave_drive = 1'b1;
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
    end
  end

  // Expected bus events: S, address, payload bytes MSB byte first, ACK/NACK
  // after each, P.
  task automatic build_exp(input vec_t v);
    logic [7:0] b;
    exp_ev.delete();
    exp_ev.push_back(EV_S);
    for (int i = 0; i <= int'(v.cnt); i++) begin
      if (i == 0) b = v.addr;
      else        b = v.data[8*(TXB-i) +: 8];
      exp_ev.push_back(int'(b));
      exp_ev.push_back((i == v.nack_byte) ? EV_N : EV_A);
`ifdef MCP4725_ACK_CHECK_EN
      if (i == v.nack_byte) break;
`endif
    end
    exp_ev.push_back(EV_P);
  endtask

  // Drives a one-cycle start at the current (post-negedge) time.
  task automatic start_frame(input vec_t v, input string tag);
    tick_div  = v.div;
    nack_byte = v.nack_byte;
    build_exp(v);
    ev.delete();
    tick_cnt = 0;
    done_cnt = 0;
    bus.dev_addr = v.addr;
    bus.tx_data  = v.data;
    bus.tx_count = v.cnt;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check($sformatf("%s busy after accept", tag), 32'(bus.busy), 32'd1);
    check($sformatf("%s nack cleared", tag), 32'(bus.nack), 32'd0);
  endtask

  task automatic finish_frame(input vec_t v, input int inject_at, input string tag);
    bit seen     = 1'b0;
    bit injected = 1'b0;
    int n;
    for (int c = 0; c < 4000 && !seen; c++) begin
      step();
      if (bus.start) bus.start = 1'b0;
      if (inject_at >= 0 && !injected && tick_cnt == inject_at) begin
        bus.dev_addr = 8'hC4;
        bus.tx_data  = 24'hFFFFFF;
        bus.tx_count = 2'd3;
        bus.start    = 1'b1;
        injected     = 1'b1;
      end
      if (bus.done) seen = 1'b1;
    end
    check($sformatf("%s done seen", tag), 32'(seen), 32'd1);
    check($sformatf("%s tick count", tag), 32'(tick_cnt), 32'(v.exp_ticks));
    check($sformatf("%s busy low with done", tag), 32'(bus.busy), 32'd0);
    repeat (3) step();
    check($sformatf("%s single done", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s nack", tag), 32'(bus.nack), 32'(v.exp_nack));
    check($sformatf("%s idle lines", tag), {30'd0, scl, sda_bus}, 32'd3);
    check($sformatf("%s event count", tag), 32'(ev.size()), 32'(exp_ev.size()));
    n = (ev.size() < exp_ev.size()) ? ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s event %0d", tag, i), 32'(ev[i]), 32'(exp_ev[i]));
  endtask

  task automatic run_frame(input vec_t v, input int inject_at, input string tag);
    step();
    start_frame(v, tag);
    finish_frame(v, inject_at, tag);
  endtask

  initial begin
    vecs[0] = '{8'hC0, 24'h0ABC00, 2'd2, -1, 4, 58, 1'b0};
    vecs[1] = '{8'hC0, 24'h000000, 2'd0, -1, 4, 22, 1'b0};
    vecs[2] = '{8'hC2, 24'h60FFF0, 2'd3, -1, 4, 76, 1'b0};
`ifdef MCP4725_ACK_CHECK_EN
    vecs[3] = '{8'hC2, 24'h0155AA, 2'd3, 1, 4, 40, 1'b1};
    vecs[4] = '{8'hC0, 24'hA55A00, 2'd2, 0, 4, 22, 1'b1};
`else
    vecs[3] = '{8'hC2, 24'h0155AA, 2'd3, 1, 4, 76, 1'b0};
    vecs[4] = '{8'hC0, 24'hA55A00, 2'd2, 0, 4, 58, 1'b0};
`endif
    vecs[5] = '{8'hC0, 24'hFF0000, 2'd1, -1, 1, 40, 1'b0};
    v0 = vecs[0];

    rst          = 1'b0;
    slave_drive  = 1'b0;
    bus.start    = 1'b0;
    bus.dev_addr = '0;
    bus.tx_data  = '0;
    bus.tx_count = '0;
    repeat (3) step();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset nack", 32'(bus.nack), 32'd0);
    check("reset scl", 32'(scl), 32'd1);
    check("reset sda released", 32'(sda_bus), 32'd1);
    rst     = 1'b1;
    tick_en = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i], -1, $sformatf("vec%0d", i));

    // New request at tick 20 of a running frame must be ignored.
    run_frame(v0, 20, "start_busy");

    // Start coincident with a tick: the tick is dropped, START waits.
    begin
      int n = 0;
      tick_div = 4;
      step();
      while (!scl_tick && n < 20) begin step(); n++; end
      start_frame(v0, "coincident");
      check("coincident no early start", 32'(sda_bus), 32'd1);
      n = 0;
      while (!scl_tick && n < 20) begin
        step();
        n++;
        if (sda_bus !== 1'b1) break;
      end
      check("coincident sda high until tick", 32'(sda_bus), 32'd1);
      step();
      check("coincident start on tick", {30'd0, scl, sda_bus}, 32'd2);
      finish_frame(v0, -1, "coincident");
    end

    // Asynchronous reset in the middle of a payload byte.
    begin
      int n = 0;
      step();
      start_frame(v0, "reset_mid");
      while (tick_cnt < 30 && n < 400) begin step(); n++; end
      check("reset_mid reached byte", 32'(tick_cnt >= 30), 32'd1);
      rst         = 1'b0;
      slave_drive = 1'b0;
      #1;
      check("reset_mid scl", 32'(scl), 32'd1);
      check("reset_mid sda released", 32'(sda_bus), 32'd1);
      check("reset_mid busy", 32'(bus.busy), 32'd0);
      repeat (2) step();
      rst = 1'b1;
      repeat (2) step();
      check("reset_mid stays idle", 32'(bus.busy), 32'd0);
      run_frame(v0, -1, "post_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mcp4725_i2c_master.md
# mcp4725_i2c_master

Byte-level I2C write engine that sits directly below the MCP4725 DAC interface and drives the physical SCL/SDA lines. It accepts a device address byte plus up to `TX_BYTES_MAX` payload bytes and sends START, address, payload, and STOP on the bus. Bit timing comes from an external half-period tick, which is the selected `clk_2x*` rate resynchronised to `clk`.

## Interface
- `TX_BYTES_MAX`, default 3: maximum payload bytes; covers the MCP4725 write-DAC-register frame.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `scl_tick` in 1: one-`clk` strobe per SCL half-period.
- `start` in 1: transaction request; sampled only in IDLE.
- `dev_addr` in 8: address byte, including the R/W bit; bit 0 must be 0.
- `tx_data` in 8*TX_BYTES_MAX: payload; byte 0 is in the MSBs.
- `tx_count` in 2: number of payload bytes, 0..TX_BYTES_MAX. Values above TX_BYTES_MAX are clamped.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `nack` out 1: the slave NACKed; held until the next accepted `start`.
- `SCL` out 1: clock line, high when released.
- `SDA` inout 1: open drain; driven only to 0, otherwise `1'bz`.

## Operation
- Reset values: `busy`=0, `done`=0, `nack`=0, `SCL`=1, `SDA`=Z. Reset releases the bus asynchronously, including mid-frame; no STOP is generated.
- States: IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_LO, STOP_HI, STOP_REL.
- IDLE: if `start`=1, latch `dev_addr`, `tx_data` and `tx_count`, clear `nack`, go to START. `busy`=1 from the next cycle.
- All following transitions occur only on `clk` edges where `scl_tick`=1.
  - START: drive `SDA`=0 with `SCL`=1, then go to BIT_LO.
  - BIT_LO: `SCL`=0; drive `SDA` with the current bit, MSB first.
  - BIT_HI: `SCL`=1. After the 8th bit go to ACK_LO, otherwise go to BIT_LO.
  - ACK_LO: `SCL`=0; release `SDA`.
  - ACK_HI: `SCL`=1. On leaving, sample `SDA`. Then either load the next byte and go to BIT_LO, or go to STOP_LO after the last byte.
  - STOP_LO: `SCL`=0, `SDA`=0.
  - STOP_HI: `SCL`=1.
  - STOP_REL: release `SDA`, pulse `done`, go to IDLE.
- Byte order: `dev_addr`, then `tx_data[8*TX_BYTES_MAX-1 -: 8]`, and so on downwards.
- `start` while `busy` is ignored. No queueing.
- `start` and `scl_tick` in the same IDLE cycle: the tick is ignored, and START waits for the next tick.
- `scl_tick` asserted on consecutive `clk` cycles is legal; each tick advances one state.

## Timing
- Accept-to-busy: 1 cycle.
- Ticks per transaction: 1 + 18·(tx_count+1) + 3.
  - tx_count=2 (fast write): 58 ticks.
  - tx_count=3: 76 ticks.
  - tx_count=0: 22 ticks.
- `done` is asserted in the cycle after the final tick. `busy` falls in that same cycle.
- `SDA` changes only while `SCL`=0, except for the START and STOP edges.

## Configuration
- `MCP4725_ACK_CHECK_EN` defined:
  - A high `SDA` sample at ACK_HI sets `nack`.
  - Remaining bytes are skipped and the engine goes straight to STOP_LO.
  - `done` still pulses.
- Undefined: ACK samples are ignored, `nack` is tied to 0, and all bytes are always sent.

## Structure
- Shared package `mcp4725_pkg` holds:
  - the state enum;
  - the MCP4725 address prefix `4'b1100`;
  - command codes: fast write `2'b00`, write DAC `3'b010`, write DAC+EEPROM `3'b011`;
  - power-down codes.
- Natural sub-module: `i2c_byte_shifter`. It is an 8-bit load/shift register with a bit counter and `last_bit` flag, used by BIT_LO/BIT_HI.

## Test plan
- **Fast write, slave ACKs:** `dev_addr`=0xC0, `tx_data`=0x0ABC00, `tx_count`=2, slave model ACKs.
  - Decoded bus: S C0 A 0A A BC A P.
  - `done` follows exactly 58 ticks; `nack`=0.
- **Address-only frame:** `tx_count`=0.
  - Bus: S C0 A P.
  - 22 ticks, then a single `done` pulse.
- **NACK on first payload byte:** slave NACKs the second byte.
  - With `MCP4725_ACK_CHECK_EN`: `nack`=1, no further bytes, STOP issued.
  - Without it: all 3 bytes sent, `nack`=0.
- **Start during busy:** pulse `start` with new data at tick 20.
  - Bus content is unchanged and only one `done` is produced.
- **Reset mid-frame:** assert `rst`=0 during byte 2.
  - Same cycle: `SCL`=1, `SDA`=Z, `busy`=0.
  - After release, a fresh `start` produces a correct frame.
- **Coincident start and tick:** assert `start` and `scl_tick` together in IDLE.
  - `SDA` falls only on the next tick, with no early START.
